// File: rtl/arb_pkg.sv
// Shared types and default sizing for the I/D memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_MEM_LAT    = 1;
  localparam int unsigned DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of D grants made while I was waiting; at_max forces an I grant.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;

  // Clear wins over increment; increment saturates at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CW'(MAX))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign at_max = (cnt_q == CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (I) and data (D) ports.
// D has fixed priority; after STARVE_MAX consecutive D grants with I waiting, I is forced.
// One access in flight at a time; every output is registered.
// Optional: define ARB_MISALIGN_CHECK_EN to reject misaligned D accesses and flag d_err.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              i_ready_d, d_ready_d, mem_en_d, mem_we_d;
  logic [DATA_W-1:0] i_rdata_d, d_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;

  logic starve_inc, starve_clr, starve_at_max;

  // Word-offset bits are dropped on the way to memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

`ifdef ARB_MISALIGN_CHECK_EN
  logic err_set, d_err_q;

  // Sticky misalign flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_err_q <= 1'b0;
    end else if (err_set) begin
      d_err_q <= 1'b1;
    end
  end

  assign d_err = d_err_q;
`else
  assign d_err = 1'b0;
`endif

  // Arbitration, sequencing and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
`ifdef ARB_MISALIGN_CHECK_EN
    err_set     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!i_req) starve_clr = 1'b1;
        if (d_req && !(i_req && starve_at_max)) begin
          owner_d    = OWN_D;
          addr_d     = {d_addr[ADDR_W-1:2], 2'b00};
          we_d       = d_we;
          wdata_d    = d_wdata;
          starve_inc = i_req;
          state_d    = ISSUE;
`ifdef ARB_MISALIGN_CHECK_EN
          // Misaligned D access never reaches memory; complete it at once with an error.
          if (d_addr[1:0] != 2'b00) begin
            state_d   = DONE;
            d_ready_d = 1'b1;
            d_rdata_d = '0;
            err_set   = 1'b1;
          end
`endif
        end else if (i_req) begin
          owner_d    = OWN_I;
          addr_d     = {i_addr[ADDR_W-1:2], 2'b00};
          we_d       = 1'b0;
          wdata_d    = '0;
          starve_clr = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        // mem_rdata is valid in the cycle the count steps down to zero.
        if (lat_q == LAT_W'(1)) begin
          state_d = DONE;
          if (owner_q == OWN_I) begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = we_q ? '0 : mem_rdata;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ISSUE) begin
      mem_en_d    = 1'b1;
      mem_we_d    = we_d;
      mem_addr_d  = addr_d;
      mem_wdata_d = wdata_d;
    end
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      lat_q     <= '0;
      i_ready   <= 1'b0;
      i_rdata   <= '0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      lat_q     <= lat_d;
      i_ready   <= i_ready_d;
      i_rdata   <= i_rdata_d;
      d_ready   <= d_ready_d;
      d_rdata   <= d_rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance driven from a per-cycle vector
// table plus hand sequences, and a MEM_LAT=3 instance for latency and mid-access reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared D-side payload; each instance has its own request and reset.
  logic        d_we;
  logic [31:0] d_addr, d_wdata;

  logic        rst1, i_req1, d_req1;
  logic [31:0] i_addr1;
  logic        i_ready1, d_ready1, d_err1, mem_en1, mem_we1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  logic        rst3, i_req3, d_req3;
  logic [31:0] i_addr3;
  logic        i_ready3, d_ready3, d_err3, mem_en3, mem_we3;
  logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_port_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(rst1), .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1),
    .i_rdata(i_rdata1), .d_req(d_req1), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready1), .d_rdata(d_rdata1), .d_err(d_err1), .mem_en(mem_en1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mem_port_arbiter #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(rst3), .i_req(i_req3), .i_addr(i_addr3), .i_ready(i_ready3),
    .i_rdata(i_rdata3), .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready3), .d_rdata(d_rdata3), .d_err(d_err3), .mem_en(mem_en3),
    .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h2002_0005;
    if (a == 32'h54) return 32'h7;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Read data is valid only in the single cycle MEM_LAT after mem_en; junk otherwise.
  logic [2:0]  v1 = '0, v3 = '0;
  logic [31:0] a1 [3];
  logic [31:0] a3 [3];
  always @(posedge clk) begin
    v1 <= {v1[1:0], mem_en1 && !mem_we1};
    a1[0] <= mem_addr1; a1[1] <= a1[0]; a1[2] <= a1[1];
    v3 <= {v3[1:0], mem_en3 && !mem_we3};
    a3[0] <= mem_addr3; a3[1] <= a3[0]; a3[2] <= a3[1];
  end
  assign mem_rdata1 = v1[0] ? mem_f(a1[0]) : 32'hDEAD_BEEF;
  assign mem_rdata3 = v3[2] ? mem_f(a3[2]) : 32'hDEAD_BEEF;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, ireq;
    logic [31:0] iaddr;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic        men, mwe;
    logic [31:0] maddr, mwdata;
    logic        irdy;
    logic [31:0] irdata;
    logic        drdy;
    logic [31:0] drdata;
    logic        derr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ireq, input logic [31:0] iaddr,
                              input logic dreq, dwe, input logic [31:0] daddr, dwdata,
                              input logic men, mwe, input logic [31:0] maddr, mwdata,
                              input logic irdy, input logic [31:0] irdata,
                              input logic drdy, input logic [31:0] drdata);
    vec_t v;
    v = '{rst, ireq, iaddr, dreq, dwe, daddr, dwdata, men, mwe, maddr, mwdata,
          irdy, irdata, drdy, drdata, 1'b0};
    return v;
  endfunction

  // Runs one D access on the chosen instance, dropping d_req on d_ready.
  task automatic d_access(input bit sel, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic saw_en, output logic [31:0] en_addr, output logic err);
    @(negedge clk);
    d_we = we; d_addr = addr; d_wdata = wdata;
    if (sel) d_req3 = 1'b1; else d_req1 = 1'b1;
    lat = -1; rdata = '0; saw_en = 1'b0; en_addr = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); #1;
      if (sel ? mem_en3 : mem_en1) begin
        saw_en  = 1'b1;
        en_addr = sel ? mem_addr3 : mem_addr1;
      end
      if (sel ? d_ready3 : d_ready1) begin
        lat   = n;
        rdata = sel ? d_rdata3 : d_rdata1;
        err   = sel ? d_err3 : d_err1;
        break;
      end
    end
    d_req1 = 1'b0; d_req3 = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rdata, en_addr;
    logic        saw_en, err;
    bit          owners[10];
    int          ng;
    logic [159:0] act, exp;

    rst1 = 1'b1; rst3 = 1'b1;
    i_req1 = 1'b0; i_addr1 = '0; d_req1 = 1'b0;
    i_req3 = 1'b0; i_addr3 = '0; d_req3 = 1'b0;
    d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // rst ireq iaddr dreq dwe daddr dwdata | men mwe maddr mwdata irdy irdata drdy drdata
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 32'h2002_0005, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h100, 1, 1, 'h50, 7,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h100, 1, 1, 'h50, 7,  1, 1, 'h50, 7, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h100, 1, 1, 'h50, 7,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 0,     1, 0, 'h100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 32'hA5A5_0100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      @(negedge clk);
      rst1 = vecs[k].rst; rst3 = vecs[k].rst;
      i_req1 = vecs[k].ireq; i_addr1 = vecs[k].iaddr;
      d_req1 = vecs[k].dreq; d_we = vecs[k].dwe;
      d_addr = vecs[k].daddr; d_wdata = vecs[k].dwdata;
      #1;
      act = {mem_en1, mem_we1, mem_addr1, mem_wdata1, i_ready1,
             vecs[k].irdy ? i_rdata1 : 32'h0, d_ready1, vecs[k].drdy ? d_rdata1 : 32'h0, d_err1};
      exp = {vecs[k].men, vecs[k].mwe, vecs[k].maddr, vecs[k].mwdata, vecs[k].irdy,
             vecs[k].irdata, vecs[k].drdy, vecs[k].drdata, vecs[k].derr};
      check($sformatf("vec%0d", k), act, exp);
    end

    // Both held: four D grants then one forced I grant, repeating.
    @(negedge clk);
    i_req1 = 1'b1; i_addr1 = 32'h200;
    d_req1 = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    ng = 0;
    for (int c = 0; c < 100 && ng < 10; c++) begin
      @(negedge clk); #1;
      if (mem_en1) begin
        owners[ng] = (mem_addr1 == 32'h300);
        ng++;
      end
    end
    check("starve_grant_count", 160'(ng), 160'(10));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (i_ready1) break;
    end
    i_req1 = 1'b0; d_req1 = 1'b0;
    for (int g = 0; g < ng; g++)
      check($sformatf("starve_owner%0d_is_d", g), 160'(owners[g]), 160'((g % 5) != 4));
    repeat (3) @(negedge clk);

    // MEM_LAT=3 load: ready five cycles after the grant.
    d_access(1'b1, 32'h54, 1'b0, 32'h0, lat, rdata, saw_en, en_addr, err);
    check("lat3_ready_cycle", 160'(lat), 160'(5));
    check("lat3_rdata", 160'(rdata), 160'(32'h7));

    // Reset in WAIT abandons the access; the held request restarts afterwards.
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h60; d_req3 = 1'b1;
    repeat (3) @(negedge clk);
    rst3 = 1'b1; #1;
    check("reset_outputs_zero",
          160'({mem_en3, mem_we3, mem_addr3, mem_wdata3, i_ready3, i_rdata3,
                d_ready3, d_rdata3, d_err3}), 160'(0));
    saw_en = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      if (d_ready3 || mem_en3) saw_en = 1'b1;
    end
    check("reset_no_activity", 160'(saw_en), 160'(0));
    rst3 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); #1;
      if (d_ready3) begin
        lat = n; rdata = d_rdata3;
        break;
      end
    end
    d_req3 = 1'b0;
    check("reset_restart_cycle", 160'(lat), 160'(5));
    check("reset_restart_rdata", 160'(rdata), 160'(32'hA5A5_0060));
    repeat (2) @(negedge clk);

    // Misaligned D access on the MEM_LAT=1 instance, then an aligned one.
    d_access(1'b0, 32'h52, 1'b0, 32'h0, lat, rdata, saw_en, en_addr, err);
`ifdef ARB_MISALIGN_CHECK_EN
    check("mis_ready_cycle", 160'(lat), 160'(1));
    check("mis_no_mem_en", 160'(saw_en), 160'(0));
    check("mis_rdata", 160'(rdata), 160'(0));
    check("mis_err", 160'(err), 160'(1));
`else
    check("mis_ready_cycle", 160'(lat), 160'(3));
    check("mis_mem_addr", 160'({saw_en, en_addr}), 160'({1'b1, 32'h50}));
    check("mis_rdata", 160'(rdata), 160'(32'hA5A5_0050));
    check("mis_err", 160'(err), 160'(0));
`endif
    d_access(1'b0, 32'h58, 1'b0, 32'h0, lat, rdata, saw_en, en_addr, err);
    check("post_mis_ready_cycle", 160'(lat), 160'(3));
    check("post_mis_rdata", 160'(rdata), 160'(32'hA5A5_0058));
`ifdef ARB_MISALIGN_CHECK_EN
    check("post_mis_err_sticky", 160'(err), 160'(1));
`else
    check("post_mis_err", 160'(err), 160'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (I) port and data-access (D) port.
- Sits between the cpu stages and the memory model.
- The pipeline treats a deasserted ready on a pending request as a stall.
- Fixed-priority arbitration (D over I) with an anti-starvation counter; one access in flight at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid (>=1).
- STARVE_MAX, 4, consecutive D grants while I is waiting before I is forced.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_req  in  1  fetch request; held with i_addr until i_ready.
- i_addr  in  ADDR_W  fetch address.
- i_ready  out  1  one-cycle completion pulse.
- i_rdata  out  DATA_W  fetched word; valid while i_ready.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  load data; valid while d_ready (0 for stores).
- d_err  out  1  sticky misalign flag (see Optional Feature).
- mem_en  out  1  memory strobe, one cycle per access.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  word address; bits [1:0] always 0.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (asynchronous, any time):
  - state goes to IDLE; lat_cnt=0, starve_cnt=0.
  - All outputs are 0; any in-flight access is abandoned.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE, winner selection:
  - D wins if d_req && !(i_req && starve_cnt==STARVE_MAX).
  - Otherwise I wins if i_req.
  - On a grant, latch owner, addr, we, wdata and go to ISSUE. No request: stay in IDLE.
- starve_cnt:
  - Increments (saturating) on each D grant made while i_req=1.
  - Clears on an I grant, or in any IDLE cycle with i_req=0.
- ISSUE:
  - mem_en=1, mem_addr/mem_we/mem_wdata driven from the latches for exactly this cycle.
  - Load lat_cnt=MEM_LAT, then go to WAIT.
- WAIT:
  - Decrement lat_cnt each cycle.
  - When lat_cnt reaches 0, capture mem_rdata into the owner's rdata register (0 for stores) and go to DONE.
- DONE:
  - Owner's ready=1 for one cycle, rdata held valid; then return to IDLE.
  - The non-owner's ready stays 0.
- Latency: request seen in IDLE at cycle 0 -> mem_en at cycle 1 -> mem_rdata at cycle 1+MEM_LAT -> ready at cycle 2+MEM_LAT.
- Throughput: one access per MEM_LAT+3 cycles. A requester may keep req high after ready to issue a back-to-back access; that access is arbitrated in the next IDLE cycle.
- Stores complete with the same timing as loads.
- A request arriving during ISSUE, WAIT or DONE waits; it is never lost.
- Dropping req before ready is illegal: the access still completes and ready still pulses.
- i_addr is word-aligned by construction; its [1:0] bits are forced to 0.

Optional Feature:
- Macro: ARB_MISALIGN_CHECK_EN.
- Defined:
  - A D grant with d_addr[1:0]!=0 skips ISSUE/WAIT (no mem_en).
  - Goes IDLE->DONE directly: d_ready the next cycle, d_rdata=0.
  - Sets sticky d_err=1, cleared only by reset.
- Undefined:
  - d_addr[1:0] is forced to 0 and the access proceeds normally.
  - d_err is tied to 0.

Decomposition:
- Package arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - arb_owner_t enum {OWN_I, OWN_D}.
  - Default constants for ADDR_W, DATA_W, MEM_LAT, STARVE_MAX.
- Sub-module arb_starve_ctr: saturating counter with increment, clear and at_max outputs.
- FSM and datapath latches stay in the top module.

Test Plan:
- MEM_LAT=1, i_req=1 at 0x0 alone, memory returns 0x20020005:
  - mem_en at cycle 1 with mem_addr=0.
  - i_ready at cycle 3 with i_rdata=0x20020005.
- Both requesters in the same IDLE cycle; d_req store of 7 to 0x50:
  - D issues first (mem_we=1, mem_addr=0x50, mem_wdata=7).
  - d_ready at cycle 3; I issues at cycle 5 and i_ready at cycle 7.
- d_req and i_req held continuously, STARVE_MAX=4:
  - Exactly 4 D grants, then 1 I grant; pattern repeats.
  - starve_cnt clears after each I grant.
- MEM_LAT=3, load from 0x54 with memory returning 7: d_ready exactly 5 cycles after the grant, d_rdata=7.
- Reset asserted in WAIT, mid-access:
  - All outputs 0 immediately, with no ready pulse.
  - After release, the still-held request restarts from IDLE.
- ARB_MISALIGN_CHECK_EN, d_addr=0x52:
  - No mem_en; d_ready next cycle with d_rdata=0; d_err=1 and stays 1.
  - A following aligned access still works.
  - Without the macro: mem_addr=0x50 and d_err=0.
